// File: rtl/data_mem_master_pkg.sv
// Shared types, constants and helpers for the data-memory initiator.
package data_mem_master_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_RESP = 2'b11
    } state_e;

    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

    // Misaligned, illegal size, or address bits above the decoded range.
    function automatic logic req_illegal(input logic [1:0] size,
                                         input logic [31:0] addr,
                                         input int unsigned aw);
        logic bad;
        bad = 1'b0;
        case (size_e'(size))
            SIZE_H:  bad = addr[0];
            SIZE_W:  bad = (addr[1:0] != 2'b00);
            SIZE_X:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        if ((addr >> aw) != WORD_ZERO) bad = 1'b1;
        return bad;
    endfunction

    // Index of the final byte read for a load of the given size.
    function automatic logic [1:0] load_last_idx(input logic [1:0] size);
        case (size_e'(size))
            SIZE_B:  return 2'd0;
            SIZE_H:  return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Zero/sign extension of the assembled load value.
    function automatic logic [31:0] load_extend(input logic [31:0] acc,
                                                input logic [1:0] size,
                                                input logic sext);
        case (size_e'(size))
            SIZE_B:  return {{24{sext & acc[7]}}, acc[7:0]};
            SIZE_H:  return {{16{sext & acc[15]}}, acc[15:0]};
            default: return acc;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_master_if.sv
// Request and memory-bus signals of the data-memory initiator.
interface data_mem_master_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;

    modport master (
        input  req, we, size, sign_ext, addr, wdata, read_data,
        output busy, done, err, rdata, address, write_data, mem_read, mem_write
    );

    modport slave (
        output req, we, size, sign_ext, addr, wdata, read_data,
        input  busy, done, err, rdata, address, write_data, mem_read, mem_write
    );
endinterface

// File: rtl/data_mem_master_byte_merge.sv
// Big-endian lane merge of store data into an existing memory word.
module mem_byte_merge
    import data_mem_master_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] merged_o
);

    // Byte lane o sits at bit 8*(3-o); 3-o equals ~o for a 2-bit offset.
    always_comb begin
        merged_o = old_i;
        case (size_e'(size_i))
            SIZE_B:  merged_o[{~offset_i, 3'b000} +: 8]         = wdata_i[7:0];
            SIZE_H:  merged_o[{~offset_i[1], 4'b0000} +: 16]    = wdata_i[15:0];
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/data_mem_master.sv
// CPU-side initiator for the byte-wide data memory: byte-serial loads,
// single-cycle word stores, read-modify-write byte/half stores.
module data_mem_master
    import data_mem_master_pkg::*;
#(
    parameter int unsigned MEM_AW = 16
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_master_if.master  bus
);

    state_e      state_q;
    logic        we_q;
    logic        sext_q;
    logic [1:0]  size_q;
    logic [1:0]  idx_q;
    logic [1:0]  last_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [31:0] merged;

    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] address_q;
    logic [31:0] write_data_q;
    logic        mem_read_q;
    logic        mem_write_q;

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.address    = address_q;
    assign bus.write_data = write_data_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;

    // Accumulator with the current memory byte shifted in; first byte ends up on top.
    always_comb begin
        acc_d = {acc_q[23:0], bus.read_data[7:0]};
    end

    // Merge sees the word including the byte arriving on the final read edge,
    // so the merged value can be registered straight into write_data.
    mem_byte_merge u_merge (
        .old_i    (acc_d),
        .wdata_i  (wdata_q),
        .size_i   (size_q),
        .offset_i (addr_q[1:0]),
        .merged_o (merged)
    );

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            sext_q       <= 1'b0;
            size_q       <= 2'b00;
            idx_q        <= 2'd0;
            last_q       <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            acc_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            address_q    <= '0;
            write_data_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        sext_q  <= bus.sign_ext;
                        size_q  <= bus.size;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        acc_q   <= '0;
                        idx_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        if (req_illegal(bus.size, bus.addr, MEM_AW)) begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= WORD_ZERO;
                        end else if (!bus.we) begin
                            state_q    <= S_RD;
                            last_q     <= load_last_idx(bus.size);
                            mem_read_q <= 1'b1;
                            address_q  <= bus.addr;
                        end else if (size_e'(bus.size) == SIZE_W) begin
                            state_q      <= S_WR;
                            mem_write_q  <= 1'b1;
                            address_q    <= bus.addr;
                            write_data_q <= bus.wdata;
                        end else begin
                            state_q    <= S_RD;
                            last_q     <= 2'd3;
                            mem_read_q <= 1'b1;
                            address_q  <= {bus.addr[31:2], 2'b00};
                        end
                    end
                end
                S_RD: begin
                    acc_q <= acc_d;
                    if (idx_q == last_q) begin
                        mem_read_q <= 1'b0;
                        if (!we_q) begin
                            state_q   <= S_RESP;
                            done_q    <= 1'b1;
                            err_q     <= 1'b0;
                            rdata_q   <= load_extend(acc_d, size_q, sext_q);
                            address_q <= '0;
                        end else begin
                            state_q      <= S_WR;
                            mem_write_q  <= 1'b1;
                            address_q    <= {addr_q[31:2], 2'b00};
                            write_data_q <= merged;
                        end
                    end else begin
                        idx_q     <= idx_q + 2'd1;
                        address_q <= address_q + 32'd1;
                    end
                end
                S_WR: begin
                    state_q      <= S_RESP;
                    mem_write_q  <= 1'b0;
                    address_q    <= '0;
                    write_data_q <= '0;
                    done_q       <= 1'b1;
                    err_q        <= 1'b0;
                    rdata_q      <= WORD_ZERO;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_master.sv
// Directed bench for data_mem_master with a behavioural byte memory and a
// per-cycle expected-trace model.
module tb_data_mem_master;

    logic clk = 1'b0;
    logic rst = 1'b0;

    initial forever #5 clk = ~clk;

    data_mem_master_if bus();

    data_mem_master #(.MEM_AW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory seen by the DUT.
    logic [7:0] mem [0:65535];
    // Independent reference image maintained by the model.
    logic [7:0] ref_mem [0:65535];

    assign bus.read_data = bus.mem_read ? {24'h0, mem[bus.address[15:0]]} : '0;

    // Word write: four bytes, most significant at the lowest address.
    always @(posedge clk) begin
        if (bus.mem_write) begin
            for (int i = 0; i < 4; i++)
                mem[bus.address[15:0] + 16'(i)] <= bus.write_data[31 - 8*i -: 8];
        end
    end

    typedef struct {
        logic        busy;
        logic        done;
        logic        err;
        logic        mr;
        logic        mw;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
    } cyc_t;

    cyc_t expq[$];
    cyc_t pend[$];
    logic [31:0] m_res;
    logic [31:0] m_base;
    logic [7:0]  m_b [4];
    bit          m_commit;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic cyc_t mk(input logic busy, input logic done, input logic err,
                                input logic mr, input logic mw, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd);
        cyc_t c;
        c.busy = busy; c.done = done; c.err = err; c.mr = mr; c.mw = mw;
        c.addr = addr; c.wd = wd; c.rd = rd;
        return c;
    endfunction

    // Expected cycle-by-cycle bus behaviour of one transaction, from the
    // request rules and the reference memory image.
    task automatic model(input bit w, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] wd);
        int          n;
        bit          bad;
        logic [31:0] v;
        logic [31:0] base;
        logic [7:0]  b [4];
        pend.delete();
        m_commit = 1'b0;
        m_res    = '0;
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
              (sz == 2'b10 && a[1:0] != 2'b00) || (a[31:16] != 16'h0);
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (bad) begin
            pend.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
            return;
        end
        if (!w) begin
            v = '0;
            for (int i = 0; i < n; i++) begin
                v = (v << 8) | {24'h0, ref_mem[16'(a + 32'(i))]};
                pend.push_back(mk(1, 0, 0, 1, 0, a + 32'(i), 0, 0));
            end
            if (sx && n < 4 && v[8*n - 1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            m_res = v;
            pend.push_back(mk(1, 1, 0, 0, 0, 0, 0, v));
        end else begin
            if (n == 4) begin
                base = a;
                for (int i = 0; i < 4; i++) b[i] = wd[31 - 8*i -: 8];
            end else begin
                base = {a[31:2], 2'b00};
                for (int i = 0; i < 4; i++) begin
                    b[i] = ref_mem[16'(base + 32'(i))];
                    pend.push_back(mk(1, 0, 0, 1, 0, base + 32'(i), 0, 0));
                end
                if (n == 1) begin
                    b[a[1:0]] = wd[7:0];
                end else begin
                    b[a[1:0]]        = wd[15:8];
                    b[a[1:0] + 2'd1] = wd[7:0];
                end
            end
            pend.push_back(mk(1, 0, 0, 0, 1, base, {b[0], b[1], b[2], b[3]}, 0));
            pend.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
            m_commit = 1'b1;
            m_base   = base;
            for (int i = 0; i < 4; i++) m_b[i] = b[i];
        end
    endtask

    // Per-cycle comparison; with nothing outstanding the unit must be idle.
    always @(negedge clk) begin
        cyc_t e;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (expq.size() > 0) e = expq.pop_front();
        chk("busy",       32'(bus.busy),      32'(e.busy));
        chk("done",       32'(bus.done),      32'(e.done));
        chk("err",        32'(bus.err),       32'(e.err));
        chk("mem_read",   32'(bus.mem_read),  32'(e.mr));
        chk("mem_write",  32'(bus.mem_write), 32'(e.mw));
        chk("address",    bus.address,        e.addr);
        chk("write_data", bus.write_data,     e.wd);
        if (e.done) chk("rdata", bus.rdata, e.rd);
    end

    task automatic drive_req(input bit w, input logic [1:0] sz, input bit sx,
                             input logic [31:0] a, input logic [31:0] wd);
        bus.req      = 1'b1;
        bus.we       = w;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.addr     = a;
        bus.wdata    = wd;
        foreach (pend[i]) expq.push_back(pend[i]);
    endtask

    task automatic op(input bit w, input logic [1:0] sz, input bit sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit has_lit, input logic [31:0] lit, input bit lit_err,
                      input bit hold);
        int n;
        model(w, sz, sx, a, wd);
        n = pend.size();
        @(negedge clk); #1;
        drive_req(w, sz, sx, a, wd);
        @(negedge clk); #1;
        if (!hold) bus.req = 1'b0;
        for (int i = 1; i < n; i++) begin
            @(negedge clk); #1;
        end
        chk("done_at_latency", 32'(bus.done), 32'd1);
        if (has_lit) begin
            chk("model_vs_lit", m_res, lit);
            chk("rdata_vs_lit", bus.rdata, lit);
            chk("err_vs_lit", 32'(bus.err), 32'(lit_err));
        end
        bus.req = 1'b0;
        if (m_commit)
            for (int i = 0; i < 4; i++) ref_mem[16'(m_base + 32'(i))] = m_b[i];
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},       32'(bus.busy),      32'd0);
        chk({tag, "_done"},       32'(bus.done),      32'd0);
        chk({tag, "_err"},        32'(bus.err),       32'd0);
        chk({tag, "_mem_read"},   32'(bus.mem_read),  32'd0);
        chk({tag, "_mem_write"},  32'(bus.mem_write), 32'd0);
        chk({tag, "_address"},    bus.address,        32'd0);
        chk({tag, "_write_data"}, bus.write_data,     32'd0);
        chk({tag, "_rdata"},      bus.rdata,          32'd0);
    endtask

    // Byte store interrupted by reset during its third read.
    task automatic reset_during_sb();
        model(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AA);
        @(negedge clk); #1;
        drive_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AA);
        @(negedge clk); #1;
        bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        expq.delete();
        #1;
        check_all_zero("midrst");
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem[16'h100] = 8'h81; mem[16'h101] = 8'h22; mem[16'h102] = 8'h33; mem[16'h103] = 8'h44;
        ref_mem[16'h100] = 8'h81; ref_mem[16'h101] = 8'h22;
        ref_mem[16'h102] = 8'h33; ref_mem[16'h103] = 8'h44;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = '0; bus.wdata = '0;

        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Loads from the preloaded word.
        op(0, 2'b10, 0, 32'h100, 0, 1, 32'h8122_3344, 0, 0);
        op(0, 2'b00, 1, 32'h100, 0, 1, 32'hFFFF_FF81, 0, 0);
        op(0, 2'b00, 0, 32'h100, 0, 1, 32'h0000_0081, 0, 0);
        op(0, 2'b01, 1, 32'h102, 0, 1, 32'h0000_3344, 0, 0);
        op(0, 2'b01, 1, 32'h100, 0, 1, 32'hFFFF_8122, 0, 0);
        op(0, 2'b01, 0, 32'h100, 0, 1, 32'h0000_8122, 0, 0);
        op(0, 2'b00, 1, 32'h103, 0, 1, 32'h0000_0044, 0, 0);

        // Word store with req held high while busy, then read back.
        op(1, 2'b10, 0, 32'h200, 32'hDEAD_BEEF, 0, 0, 0, 1);
        op(0, 2'b10, 0, 32'h200, 0, 1, 32'hDEAD_BEEF, 0, 0);

        // Error requests.
        op(0, 2'b01, 0, 32'h101, 0, 1, 32'h0, 1, 0);
        op(0, 2'b10, 0, 32'h102, 0, 1, 32'h0, 1, 0);
        op(0, 2'b11, 0, 32'h100, 0, 1, 32'h0, 1, 0);
        op(0, 2'b10, 0, 32'h0001_0000, 0, 1, 32'h0, 1, 0);
        op(1, 2'b01, 0, 32'h103, 32'h1234, 1, 32'h0, 1, 0);

        // Reset during a byte store leaves memory untouched.
        reset_during_sb();
        op(0, 2'b10, 0, 32'h100, 0, 1, 32'h8122_3344, 0, 0);

        // Read-modify-write stores.
        op(1, 2'b00, 0, 32'h101, 32'h0000_00AA, 0, 0, 0, 0);
        op(0, 2'b10, 0, 32'h100, 0, 1, 32'h81AA_3344, 0, 0);
        op(1, 2'b01, 0, 32'h102, 32'h0000_5555, 0, 0, 0, 0);
        op(0, 2'b10, 0, 32'h100, 0, 1, 32'h81AA_5555, 0, 0);
        op(1, 2'b00, 0, 32'h100, 32'hFFFF_FF10, 0, 0, 0, 1);
        op(1, 2'b01, 0, 32'h200, 32'hABCD_0102, 0, 0, 0, 0);
        op(0, 2'b10, 0, 32'h100, 0, 1, 32'h10AA_5555, 0, 0);
        op(0, 2'b10, 0, 32'h200, 0, 1, 32'h0102_BEEF, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_master.md
Name: data_mem_master

Overview:
- CPU-side initiator for the byte-addressed data memory (`data_mem`).
- Accepts one load/store request at a time from the pipeline's MEM stage.
- Drives the memory's address, write_data, mem_read and mem_write; samples read_data.
- The memory returns one byte per read (mem[address] zero-extended, Z when mem_read=0), so loads are assembled big-endian from sequential byte reads. Word stores are written in one cycle; byte/half stores are done as read-modify-write of the aligned word.

Parameters:
- MEM_AW, 16, memory address bits actually decoded; a request with nonzero addr[31:MEM_AW] is an error.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous active-high reset
- req  input  1  request strobe, sampled only in IDLE
- we  input  1  1=store, 0=load
- size  input  2  00=byte, 01=half, 10=word, 11=illegal
- sign_ext  input  1  loads only: 1=sign-extend, 0=zero-extend
- addr  input  32  byte address
- wdata  input  32  store data; byte/half taken from LSBs
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: misaligned, out-of-range or size=11
- rdata  output  32  load result, valid while done=1, held until next accept
- address  output  32  to memory
- write_data  output  32  to memory
- mem_read  output  1  to memory
- mem_write  output  1  to memory

Behaviour:
- Reset (async): state=IDLE, all outputs 0, internal accumulator and byte counter cleared.
- Reset mid-operation: abort at once. mem_write drops asynchronously, so no write reaches memory. Memory contents are unchanged and no done pulse is produced.
- States: IDLE, RD, WR, RESP.
- IDLE: address, write_data, mem_read and mem_write are all 0. On a posedge with req=1, latch we/size/sign_ext/addr/wdata.
  - Error request (half with addr[0]=1, word with addr[1:0]!=0, size=11, or addr out of range) -> RESP with err=1. No memory cycle is issued.
  - Load -> RD with N=1/2/4 bytes starting at addr.
  - Word store -> WR.
  - Byte/half store -> RD reading the 4 bytes at {addr[31:2],2'b00}.
- RD: mem_read=1, address=base+idx.
  - On each posedge, shift read_data[7:0] into the accumulator LSB (first byte ends up most significant) and increment idx.
  - After byte N-1: load -> RESP; RMW store -> WR.
  - read_data is sampled only while mem_read=1.
- WR: mem_write=1 for exactly one cycle. address is the latched addr (word store) or the aligned base (RMW). write_data is wdata (word) or the merged word. The memory writes at the next posedge, then the unit goes to RESP.
- Merge rule, offset o=addr[1:0], big-endian lanes:
  - byte: replace bits [31-8o -: 8] with wdata[7:0].
  - half: replace bits [31-8o -: 16] with wdata[15:0] (o is 0 or 2).
- RESP: done=1 and busy=1 for one cycle, then IDLE. rdata is zero- or sign-extended from bit 7 (byte), bit 15 (half) or none (word). Store and error responses drive rdata=0.
- req while busy is ignored, not queued. A new request is accepted on the first posedge after RESP.
- Latency, counted in edges after the accept edge: done appears after N+1 edges for loads, 2 for word stores, 6 for byte/half stores, 1 for errors.
- mem_read and mem_write are never high together. address is stable throughout each RD byte cycle and through WR.

Decomposition:
- Shared package / constant_values.vh holds:
  - size codes SIZE_B, SIZE_H, SIZE_W;
  - state encodings S_IDLE, S_RD, S_WR, S_RESP;
  - the existing WORD_ZERO.
- One combinational sub-module, mem_byte_merge (inputs: old word, wdata, size, offset; output: merged word). It is reused later by a byte-enable cache path.

Test Plan:
- Memory preloaded with 0x100..0x103 = 81,22,33,44. LW 0x100 -> 4 read cycles at addresses 0x100..0x103, then done with rdata=0x81223344, err=0.
- LB sign_ext=1 at 0x100 -> rdata=0xFFFFFF81. LBU at 0x100 -> 0x00000081. LH sign_ext=1 at 0x102 -> 0x00003344. LH at 0x100 -> 0xFFFF8122.
- SW 0x200 with wdata=0xDEADBEEF -> one mem_write cycle at address 0x200, done on the 2nd edge. A following LW 0x200 returns 0xDEADBEEF.
- SB 0x101 with wdata=0x000000AA -> reads 0x100..0x103, then one write of 0x81AA3344 at 0x100. SH 0x102 with wdata=0x5555 -> 0x81AA5555.
- LH 0x101, LW 0x102, size=11, and addr=0x00010000 -> each gives done with err=1 on the 1st edge; mem_read and mem_write stay 0.
- Assert rst during the 3rd read of an SB -> all outputs 0 immediately and no write occurs; memory at 0x100 still reads 0x81223344. A req held high while busy produces no extra transaction.
